// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port pipelined RAM.
package ram_pkg;

   // Width of one byte-lane covered by a single write-mask bit.
   localparam int LANE_W = 8;

   // Post-reset clear sweep state.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } clr_state_t;

endpackage

// File: rtl/ram_dp_clr.sv
// Clear sweep controller: zero-fills addresses 0..DEPTH-1 after reset, one per cycle.
module ram_dp_clr
   import ram_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int DEPTH    = 4096,
   parameter int CLEAR_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              busy,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              clr_we
);

   clr_state_t state;

   // Sweep FSM; the counter holds the address written on the next edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= (CLEAR_EN != 0) ? ST_CLEAR : ST_READY;
         clr_addr <= '0;
      end else if (state == ST_CLEAR) begin
         if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state <= ST_READY;
         end else begin
            clr_addr <= clr_addr + 1'b1;
         end
      end
   end

   assign busy   = (state == ST_CLEAR);
   // No memory write on a reset edge, so a held reset never disturbs contents.
   assign clr_we = busy && rst_n;

endmodule

// File: rtl/ram_dp_pipe.sv
// Dual-port byte-masked RAM with write-first read merge, 1- or 2-cycle read
// pipeline, post-reset zero-fill and out-of-range error reporting.
module ram_dp_pipe
   import ram_pkg::*;
#(
   parameter int DATA_W   = 24,   // multiple of LANE_W
   parameter int ADDR_W   = 12,
   parameter int DEPTH    = 4096, // DEPTH <= 2**ADDR_W
   parameter int RD_LAT   = 1,    // 1 or 2
   parameter int CLEAR_EN = 1
) (
   input  logic                     CK,
   input  logic                     RST_N,
   input  logic                     WE,
   input  logic [ADDR_W-1:0]        WA,
   input  logic [DATA_W-1:0]        D,
   input  logic [DATA_W/LANE_W-1:0] WM,
   input  logic                     RE,
   input  logic [ADDR_W-1:0]        RA,
   input  logic                     OE,
   output logic [DATA_W-1:0]        Q,
   output logic                     QV,
   output logic                     BUSY,
   output logic                     ERR
);

   localparam int NUM_LANES = DATA_W / LANE_W;
   localparam int STAGES    = RD_LAT - 1;
   // One extra bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   typedef logic [NUM_LANES-1:0][LANE_W-1:0] word_t;

   word_t              mem [DEPTH];
   word_t              d_l;
   word_t              rd_word;
   logic [ADDR_W-1:0]  clr_addr;
   logic               clr_we;
   logic               wa_ok;
   logic               ra_ok;
   logic               wr_go;
   logic               rd_go;
   logic [STAGES:0]    vld_pipe;
   word_t [STAGES:0]   dat_pipe;

   ram_dp_clr #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .CLEAR_EN (CLEAR_EN)
   ) u_clr (
      .clk      (CK),
      .rst_n    (RST_N),
      .busy     (BUSY),
      .clr_addr (clr_addr),
      .clr_we   (clr_we)
   );

   assign d_l   = D;
   assign wa_ok = ({1'b0, WA} < DEPTH_X);
   assign ra_ok = ({1'b0, RA} < DEPTH_X);
   // Requests are ignored while sweeping and never touch memory on a reset edge.
   assign wr_go = RST_N && !BUSY && WE && wa_ok;
   assign rd_go = !BUSY && RE;

   // Memory write port, shared by the clear sweep and masked user writes.
   always_ff @(posedge CK) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_go) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (WM[i]) mem[WA][i] <= d_l[i];
         end
      end
   end

   // Read word as seen at the accepting edge: same-address writes win per lane,
   // out-of-range reads return zero.
   always_comb begin
      rd_word = '0;
      if (ra_ok) begin
         rd_word = mem[RA];
         if (wr_go && (WA == RA)) begin
            for (int i = 0; i < NUM_LANES; i++) begin
               if (WM[i]) rd_word[i] = d_l[i];
            end
         end
      end
   end

   // Read pipeline; the last stage is the output data register and holds
   // its value until the next valid result arrives.
   always_ff @(posedge CK) begin
      if (!RST_N) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
         ERR      <= 1'b0;
      end else begin
         vld_pipe[0] <= rd_go;
         if (rd_go) dat_pipe[0] <= rd_word;
         for (int s = 1; s <= STAGES; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
         end
         // A combined bad write and bad read still yields one pulse.
         ERR <= !BUSY && ((WE && !wa_ok) || (RE && !ra_ok));
      end
   end

   assign QV = vld_pipe[STAGES];
   assign Q  = OE ? dat_pipe[STAGES] : 'z;

endmodule

// File: tb/tb_ram_dp_pipe.sv
// Directed bench for ram_dp_pipe at DEPTH=4000, RD_LAT=2, CLEAR_EN=1.
module tb_ram_dp_pipe;

   logic        ck = 1'b0;
   logic        rst_n, we, re, oe;
   logic [11:0] wa, ra;
   logic [23:0] d;
   logic [2:0]  wm;
   wire  [23:0] q;
   logic        qv, busy, err;

   int n_vec = 0;
   int n_err = 0;
   int n;
   logic seen;

   always #5 ck = ~ck;

   ram_dp_pipe #(
      .DATA_W(24), .ADDR_W(12), .DEPTH(4000), .RD_LAT(2), .CLEAR_EN(1)
   ) dut (
      .CK(ck), .RST_N(rst_n), .WE(we), .WA(wa), .D(d), .WM(wm),
      .RE(re), .RA(ra), .OE(oe), .Q(q), .QV(qv), .BUSY(busy), .ERR(err)
   );

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output disabled: a four-state simulator shows Z, a two-state one shows 0;
   // either way the data register must not reach Q.
   task automatic chk_z(input string tag);
      n_vec++;
      assert (q === 24'hzzzzzz || q === 24'h000000) else begin
         n_err++;
         $error("FAIL %s: observed %h expected zzzzzz", tag, q);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [23:0] dat, input logic [2:0] m);
      we = 1'b1; wa = a; d = dat; wm = m;
      tick();
      we = 1'b0;
      chk("wr_err", {31'd0, err}, 32'd0);
   endtask

   task automatic rd(input logic [11:0] a, input logic [23:0] exp, input string tag);
      re = 1'b1; ra = a;
      tick();
      re = 1'b0;
      chk({tag, "_qv_early"}, {31'd0, qv}, 32'd0);
      tick();
      chk({tag, "_qv"}, {31'd0, qv}, 32'd1);
      chk({tag, "_q"}, {8'd0, q}, {8'd0, exp});
   endtask

   task automatic count_sweep();
      n = 0; seen = 1'b0;
      while (busy && n < 5000) begin
         if (n == 100) begin
            we = 1'b1; wa = 12'd4000; d = 24'hFFFFFF; wm = 3'b111;
            re = 1'b1; ra = 12'd4095;
         end else begin
            we = 1'b0; re = 1'b0;
         end
         tick();
         n++;
         if (qv || err) seen = 1'b1;
      end
      we = 1'b0; re = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; re = 1'b0; oe = 1'b1;
      wa = '0; ra = '0; d = '0; wm = '0;

      // reset state
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_qv",   {31'd0, qv},   32'd0);
      chk("rst_err",  {31'd0, err},  32'd0);
      chk("rst_q",    {8'd0, q},     32'd0);
      rst_n = 1'b1;

      // clear sweep length; requests during it are ignored
      count_sweep();
      chk("sweep_len",   n, 32'd4000);
      chk("sweep_quiet", {31'd0, seen}, 32'd0);
      rd(12'd0,    24'h000000, "rd0");
      rd(12'd3999, 24'h000000, "rd3999");

      // byte-lane masking
      wr(12'd5, 24'h123456, 3'b111);
      wr(12'd5, 24'hAB0000, 3'b100);
      rd(12'd5, 24'hAB3456, "rd5");
      tick();
      chk("hold_q",  {8'd0, q},     32'h00AB3456);
      chk("hold_qv", {31'd0, qv},   32'd0);

      // out-of-range write
      we = 1'b1; wa = 12'd4000; d = 24'hFFFFFF; wm = 3'b111;
      tick();
      we = 1'b0;
      chk("oobw_err", {31'd0, err}, 32'd1);
      tick();
      chk("oobw_err_end", {31'd0, err}, 32'd0);

      // out-of-range read
      re = 1'b1; ra = 12'd4095;
      tick();
      re = 1'b0;
      chk("oobr_err", {31'd0, err}, 32'd1);
      chk("oobr_qv_early", {31'd0, qv}, 32'd0);
      tick();
      chk("oobr_err_end", {31'd0, err}, 32'd0);
      chk("oobr_qv", {31'd0, qv}, 32'd1);
      chk("oobr_q",  {8'd0, q},   32'd0);

      // simultaneous out-of-range write and read
      we = 1'b1; wa = 12'd4001; re = 1'b1; ra = 12'd4002;
      tick();
      we = 1'b0; re = 1'b0;
      chk("both_err", {31'd0, err}, 32'd1);
      tick();
      chk("both_err_end", {31'd0, err}, 32'd0);
      chk("both_qv", {31'd0, qv}, 32'd1);
      rd(12'd0, 24'h000000, "rd0_after_oob");

      // write-first merge, then a later write must not disturb in-flight data
      wr(12'd7, 24'h111111, 3'b111);
      we = 1'b1; wa = 12'd7; d = 24'h00FF00; wm = 3'b010;
      re = 1'b1; ra = 12'd7;
      tick();
      re = 1'b0; d = 24'h000000; wm = 3'b111;
      chk("wf_qv_early", {31'd0, qv}, 32'd0);
      tick();
      we = 1'b0;
      chk("wf_qv", {31'd0, qv}, 32'd1);
      chk("wf_q",  {8'd0, q},   32'h0011FF11);
      rd(12'd7, 24'h000000, "rd7_late");

      // back-to-back reads with OE toggling
      wr(12'd1, 24'h0A0A01, 3'b111);
      wr(12'd2, 24'h0B0B02, 3'b111);
      wr(12'd3, 24'h0C0C03, 3'b111);
      re = 1'b1; ra = 12'd1; oe = 1'b1;
      tick();
      chk("b2b_qv0", {31'd0, qv}, 32'd0);
      ra = 12'd2; oe = 1'b0;
      tick();
      chk("b2b_qv1", {31'd0, qv}, 32'd1);
      chk_z("b2b_z1");
      ra = 12'd3; oe = 1'b1;
      tick();
      chk("b2b_qv2", {31'd0, qv}, 32'd1);
      chk("b2b_q2",  {8'd0, q},   32'h000B0B02);
      re = 1'b0; oe = 1'b0;
      tick();
      chk("b2b_qv3", {31'd0, qv}, 32'd1);
      chk_z("b2b_z3");
      oe = 1'b1;
      #1;
      chk("b2b_q3", {8'd0, q}, 32'h000C0C03);
      tick();
      chk("b2b_qv_end", {31'd0, qv}, 32'd0);

      // reset flushes an in-flight read, then restart mid-sweep
      wr(12'd3999, 24'h777777, 3'b111);
      re = 1'b1; ra = 12'd5;
      tick();
      re = 1'b0; rst_n = 1'b0;
      tick();
      chk("flush_qv",   {31'd0, qv},   32'd0);
      chk("flush_busy", {31'd0, busy}, 32'd1);
      chk("flush_q",    {8'd0, q},     32'd0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (2000) begin
         tick();
         if (qv) seen = 1'b1;
      end
      chk("mid_busy",  {31'd0, busy}, 32'd1);
      chk("mid_quiet", {31'd0, seen}, 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      count_sweep();
      chk("sweep2_len",   n, 32'd4000);
      chk("sweep2_quiet", {31'd0, seen}, 32'd0);
      rd(12'd5,    24'h000000, "rd5_cleared");
      rd(12'd3999, 24'h000000, "rd3999_cleared");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
